// File: rtl/btn_led_pkg.sv
// Package: btn_led_pkg
// Shared encodings for the button/LED combiner.
//   mode_e     : runtime combine mode selected by the 2-bit mode input
//   db_state_e : per-button debounce FSM state
//                (S_LO stable low, W_HI waiting for high,
//                 S_HI stable high, W_LO waiting for low)
package btn_led_pkg;

    typedef enum logic [1:0] {
        MODE_AND = 2'b00,
        MODE_OR  = 2'b01,
        MODE_XOR = 2'b10,
        MODE_MAJ = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_LO = 2'b00,
        W_HI = 2'b01,
        S_HI = 2'b10,
        W_LO = 2'b11
    } db_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Module: btn_debounce
// One push-button channel: 2-flop synchroniser followed by a 4-state debounce
// FSM with a saturating stability counter. A new level is accepted only after
// DB_COUNT consecutive cycles of the synchronised input at that level.
// Ports:
//   clk     in  1  system clock
//   rst_n   in  1  synchronous reset, active low
//   btn     in  1  raw asynchronous button level, 1 = pressed
//   btn_db  out 1  debounced level (1 in S_HI and W_LO)
module btn_debounce
    import btn_led_pkg::*;
#(
    parameter int DB_COUNT = 50000,
    parameter int DB_CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_db
);

    localparam logic [DB_CNT_W-1:0] CNT_ONE  = DB_CNT_W'(1);
    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_COUNT - 1);

    logic                sync1_reg;
    logic                sync2_reg;
    db_state_e           state_reg,  state_next;
    logic [DB_CNT_W-1:0] cnt_reg,    cnt_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            state_reg <= S_LO;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The counter holds the number of consecutive cycles the synchronised
    // input has shown the candidate level. The >= compare (rather than ==)
    // means the counter can never step past CNT_LAST, so it cannot wrap.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_LO: begin
                if (sync2_reg) begin
                    state_next = W_HI;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            W_HI: begin
                if (!sync2_reg) begin
                    state_next = S_LO;
                    cnt_next   = '0;
                end else if (cnt_reg >= CNT_LAST) begin
                    state_next = S_HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            S_HI: begin
                if (!sync2_reg) begin
                    state_next = W_LO;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            W_LO: begin
                if (sync2_reg) begin
                    state_next = S_HI;
                    cnt_next   = '0;
                end else if (cnt_reg >= CNT_LAST) begin
                    state_next = S_LO;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = S_LO;
                cnt_next   = '0;
            end
        endcase
    end

    assign btn_db = (state_reg == S_HI) || (state_reg == W_LO);

endmodule

// File: rtl/btn_led_combiner.sv
// Module: btn_led_combiner
// Debounces N_BTN buttons, combines the debounced levels with a runtime mode
// (AND / OR / XOR / majority) into a registered LED, and produces a one-cycle
// press event on every rising edge of that LED.
// Optional feature macro: LED_BLINK_EN
//   defined   : led1 blinks with half-period BLINK_DIV while led0 is on,
//               starting high on the cycle led0 rises; 0 while led0 is off.
//   undefined : led1 is a registered copy of led0 (no blink counter).
// Ports:
//   clk        in  1      system clock
//   rst_n      in  1      synchronous reset, active low
//   btn        in  N_BTN  raw asynchronous button levels, 1 = pressed
//   mode       in  2      00 AND, 01 OR, 10 XOR, 11 majority
//   btn_db     out N_BTN  debounced button levels
//   led0       out 1      registered combined result
//   led1       out 1      secondary LED (copy of led0, or blink)
//   press_evt  out 1      1-cycle pulse, one cycle after each led0 0->1
module btn_led_combiner
    import btn_led_pkg::*;
#(
    parameter int N_BTN     = 2,
    parameter int DB_COUNT  = 50000,
    parameter int DB_CNT_W  = 16,
    parameter int BLINK_DIV = 2**23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    input  logic [1:0]       mode,
    output logic [N_BTN-1:0] btn_db,
    output logic             led0,
    output logic             led1,
    output logic             press_evt
);

    localparam int POP_W = $clog2(N_BTN + 1);

    // ------------------------------------------------------------------
    // Per-button debouncers
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_db
            btn_debounce #(
                .DB_COUNT (DB_COUNT),
                .DB_CNT_W (DB_CNT_W)
            ) u_db (
                .clk    (clk),
                .rst_n  (rst_n),
                .btn    (btn[gi]),
                .btn_db (btn_db[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Combine logic. mode is used directly; it is quasi-static, so the
    // single register stage on led0 is the only timing boundary.
    // ------------------------------------------------------------------
    logic [POP_W-1:0] ones;
    logic             maj;
    logic             led0_next;

    always_comb begin
        ones = '0;
        for (int i = 0; i < N_BTN; i++) begin
            ones = ones + POP_W'(btn_db[i]);
        end
    end

    // Strict majority: more than half of the buttons pressed.
    assign maj = (ones > POP_W'(N_BTN / 2));

    always_comb begin
        led0_next = 1'b0;
        case (mode_e'(mode))
            MODE_AND: led0_next = &btn_db;
            MODE_OR:  led0_next = |btn_db;
            MODE_XOR: led0_next = ^btn_db;
            MODE_MAJ: led0_next = maj;
            default:  led0_next = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // LED register and edge detector
    // ------------------------------------------------------------------
    logic led0_reg;
    logic led0_q_reg;
    logic press_reg;
    logic led1_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led0_reg   <= 1'b0;
            led0_q_reg <= 1'b0;
            press_reg  <= 1'b0;
        end else begin
            led0_reg   <= led0_next;
            led0_q_reg <= led0_reg;
            // Both terms are registered, so the pulse lands one cycle
            // after led0 rises; reset clears both, so leaving reset
            // cannot manufacture an edge.
            press_reg  <= led0_reg & ~led0_q_reg;
        end
    end

    // ------------------------------------------------------------------
    // Secondary LED
    // ------------------------------------------------------------------
`ifdef LED_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_reg;

    // Decisions use led0_next so led1 moves on the same cycle as led0:
    // it goes high together with led0 and drops together with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_reg <= '0;
            led1_reg      <= 1'b0;
        end else if (!led0_next) begin
            blink_cnt_reg <= '0;
            led1_reg      <= 1'b0;
        end else if (!led0_reg) begin
            blink_cnt_reg <= '0;
            led1_reg      <= 1'b1;
        end else if (blink_cnt_reg >= BLINK_LAST) begin
            blink_cnt_reg <= '0;
            led1_reg      <= ~led1_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
        end
    end
`else
    // Loaded from the same next-state value as led0 so the two LEDs
    // are identical every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led1_reg <= 1'b0;
        end else begin
            led1_reg <= led0_next;
        end
    end
`endif

    assign led0      = led0_reg;
    assign led1      = led1_reg;
    assign press_evt = press_reg;

endmodule
